vadd_ctrl_chain: RTL and testbench

Parametrised kernel control sequencer for the vadd kernel family; successor to the single-engine ap_ctrl_hs done/idle logic in the kernel top level. Converts the host ap_start level into per-channel start pulses for NUM_CHANNELS vadd engines. Aggregates their done pulses under a runtime channel-enable mask and implements ap_ctrl_hs or ap_ctrl_chain handshaking. Also latches the transfer size and reports a run-cycle count for profiling.

---
 rtl/vadd_ctrl_pkg.sv | 21 ++
 rtl/vadd_ctrl_chain_if.sv | 32 +++
 rtl/vadd_sat_counter.sv | 24 ++
 rtl/vadd_ctrl_chain.sv | 134 +++++++++++++
 tb/tb_vadd_ctrl_chain.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vadd_ctrl_pkg.sv
// Shared types and constants for the vadd kernel control sequencer.
package vadd_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StRun,
    StDoneWait
  } state_e;

  localparam int unsigned LP_DEFAULT_LENGTH_IN_BYTES = 16384;

  localparam int unsigned CTRL_HS    = 0;
  localparam int unsigned CTRL_CHAIN = 1;

  // The run-cycle counter advances while engines are being launched or running.
  function automatic logic is_busy(state_e s);
    return (s == StLaunch) || (s == StRun);
  endfunction

endpackage

// File: rtl/vadd_ctrl_chain_if.sv
// Host/engine handshake bundle for the vadd control sequencer.
interface vadd_ctrl_chain_if #(
  parameter int unsigned NUM_CHANNELS    = 4,
  parameter int unsigned XFER_SIZE_WIDTH = 32,
  parameter int unsigned CYCLE_CNT_WIDTH = 32
);

  logic                       ap_start;
  logic                       ap_continue;
  logic                       ap_idle;
  logic                       ap_done;
  logic                       ap_ready;
  logic [XFER_SIZE_WIDTH-1:0] scalar_xfer_size;
  logic [NUM_CHANNELS-1:0]    scalar_ch_mask;
  logic [XFER_SIZE_WIDTH-1:0] ch_xfer_size_in_bytes;
  logic [NUM_CHANNELS-1:0]    ch_start;
  logic [NUM_CHANNELS-1:0]    ch_done;
  logic [CYCLE_CNT_WIDTH-1:0] run_cycles;

  // Host and engine side: drives requests, observes status.
  modport master (
    output ap_start, ap_continue, scalar_xfer_size, scalar_ch_mask, ch_done,
    input  ap_idle, ap_done, ap_ready, ch_xfer_size_in_bytes, ch_start, run_cycles
  );

  // Sequencer side.
  modport slave (
    input  ap_start, ap_continue, scalar_xfer_size, scalar_ch_mask, ch_done,
    output ap_idle, ap_done, ap_ready, ch_xfer_size_in_bytes, ch_start, run_cycles
  );

endinterface

// File: rtl/vadd_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
module vadd_sat_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_q <= '0;
    end else if (en && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/vadd_ctrl_chain.sv
// Kernel control sequencer: turns the host ap_start level into per-engine start pulses and
// aggregates engine dones into ap_ctrl_hs or ap_ctrl_chain handshakes.
module vadd_ctrl_chain
  import vadd_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS            = 4,
  parameter int unsigned CHAIN_MODE              = CTRL_HS,
  parameter int unsigned XFER_SIZE_WIDTH         = 32,
  parameter int unsigned DEFAULT_LENGTH_IN_BYTES = LP_DEFAULT_LENGTH_IN_BYTES,
  parameter int unsigned CYCLE_CNT_WIDTH         = 32
) (
  input logic              ap_clk,
  input logic              areset,
  vadd_ctrl_chain_if.slave ctrl
);

  localparam bit ChainMode = (CHAIN_MODE == CTRL_CHAIN);
  localparam logic [XFER_SIZE_WIDTH-1:0] DefaultSize = XFER_SIZE_WIDTH'(DEFAULT_LENGTH_IN_BYTES);

  state_e                     state_q, state_d;
  logic                       ap_start_r;
  logic                       pending_q, pending_d;
  logic [NUM_CHANNELS-1:0]    mask_q, mask_d;
  logic [NUM_CHANNELS-1:0]    done_r, done_d;
  logic [NUM_CHANNELS-1:0]    hits;
  logic [XFER_SIZE_WIDTH-1:0] size_q, size_d;
  logic                       idle_q, idle_d;
  logic                       ap_done_q, ap_done_d;
  logic                       ready_q, ready_d;
  logic [NUM_CHANNELS-1:0]    ch_start_q, ch_start_d;
  logic                       start_edge;
  logic                       launch;
  logic                       complete;
  logic                       cnt_clr;
  logic                       cnt_en;
  logic [CYCLE_CNT_WIDTH-1:0] run_cycles;

  assign start_edge = ctrl.ap_start & ~ap_start_r;
  // Dones from disabled channels never contribute.
  assign hits = done_r | (ctrl.ch_done & mask_q);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    mask_d    = mask_q;
    done_d    = done_r;
    size_d    = size_q;
    launch    = 1'b0;
    complete  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_edge || pending_q) begin
          launch    = 1'b1;
          state_d   = StLaunch;
          pending_d = 1'b0;
          done_d    = '0;
          size_d    = (ctrl.scalar_xfer_size == '0) ? DefaultSize : ctrl.scalar_xfer_size;
          mask_d    = (ctrl.scalar_ch_mask == '0) ? '1 : ctrl.scalar_ch_mask;
        end
      end
      StLaunch: state_d = StRun;
      StRun: begin
        done_d = hits;
        if (hits == mask_q) begin
          complete = 1'b1;
          state_d  = ChainMode ? StDoneWait : StIdle;
        end
      end
      StDoneWait: begin
        if (ctrl.ap_continue) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // One-deep start queue; edges beyond the first are dropped.
    if ((state_q != StIdle) && start_edge) begin
      pending_d = 1'b1;
    end

    idle_d     = (state_d == StIdle);
    ap_done_d  = complete | (state_d == StDoneWait);
    ready_d    = complete;
    ch_start_d = (state_d == StLaunch) ? mask_d : '0;
    cnt_clr    = launch;
    cnt_en     = is_busy(state_q);
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state_q    <= StIdle;
      ap_start_r <= 1'b0;
      pending_q  <= 1'b0;
      mask_q     <= '1;
      done_r     <= '0;
      size_q     <= DefaultSize;
      idle_q     <= 1'b1;
      ap_done_q  <= 1'b0;
      ready_q    <= 1'b0;
      ch_start_q <= '0;
    end else begin
      state_q    <= state_d;
      ap_start_r <= ctrl.ap_start;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      done_r     <= done_d;
      size_q     <= size_d;
      idle_q     <= idle_d;
      ap_done_q  <= ap_done_d;
      ready_q    <= ready_d;
      ch_start_q <= ch_start_d;
    end
  end

  vadd_sat_counter #(
    .Width(CYCLE_CNT_WIDTH)
  ) u_run_cnt (
    .clk  (ap_clk),
    .rst  (areset),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .count(run_cycles)
  );

  assign ctrl.ap_idle               = idle_q;
  assign ctrl.ap_done               = ap_done_q;
  assign ctrl.ap_ready              = ready_q;
  assign ctrl.ch_start              = ch_start_q;
  assign ctrl.ch_xfer_size_in_bytes = size_q;
  assign ctrl.run_cycles            = run_cycles;

endmodule

// File: tb/tb_vadd_ctrl_chain.sv
// Bench for vadd_ctrl_chain: hs, chain and narrow-counter instances share one stimulus stream
// and are checked every cycle against a transaction-level model plus directed literal checks.
module tb_vadd_ctrl_chain;

  localparam int unsigned Def = 16384;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ap_start = 1'b0;
  logic        ap_continue = 1'b0;
  logic [3:0]  mask = 4'h0;
  logic [3:0]  ch_done = 4'h0;
  logic [31:0] size = 32'h0;
  logic        chk_en = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vadd_ctrl_chain_if #(.NUM_CHANNELS(4), .XFER_SIZE_WIDTH(32), .CYCLE_CNT_WIDTH(32)) if0 ();
  vadd_ctrl_chain_if #(.NUM_CHANNELS(4), .XFER_SIZE_WIDTH(32), .CYCLE_CNT_WIDTH(32)) if1 ();
  vadd_ctrl_chain_if #(.NUM_CHANNELS(4), .XFER_SIZE_WIDTH(32), .CYCLE_CNT_WIDTH(4))  if2 ();

  vadd_ctrl_chain #(
    .NUM_CHANNELS(4), .CHAIN_MODE(0), .XFER_SIZE_WIDTH(32),
    .DEFAULT_LENGTH_IN_BYTES(Def), .CYCLE_CNT_WIDTH(32)
  ) dut_hs (.ap_clk(clk), .areset(rst), .ctrl(if0));

  vadd_ctrl_chain #(
    .NUM_CHANNELS(4), .CHAIN_MODE(1), .XFER_SIZE_WIDTH(32),
    .DEFAULT_LENGTH_IN_BYTES(Def), .CYCLE_CNT_WIDTH(32)
  ) dut_chain (.ap_clk(clk), .areset(rst), .ctrl(if1));

  vadd_ctrl_chain #(
    .NUM_CHANNELS(4), .CHAIN_MODE(0), .XFER_SIZE_WIDTH(32),
    .DEFAULT_LENGTH_IN_BYTES(Def), .CYCLE_CNT_WIDTH(4)
  ) dut_sat (.ap_clk(clk), .areset(rst), .ctrl(if2));

  assign if0.ap_start = ap_start;          assign if1.ap_start = ap_start;
  assign if2.ap_start = ap_start;
  assign if0.ap_continue = ap_continue;    assign if1.ap_continue = ap_continue;
  assign if2.ap_continue = ap_continue;
  assign if0.scalar_xfer_size = size;      assign if1.scalar_xfer_size = size;
  assign if2.scalar_xfer_size = size;
  assign if0.scalar_ch_mask = mask;        assign if1.scalar_ch_mask = mask;
  assign if2.scalar_ch_mask = mask;
  assign if0.ch_done = ch_done;            assign if1.ch_done = ch_done;
  assign if2.ch_done = ch_done;

  logic        a_idle  [3];
  logic        a_done  [3];
  logic        a_ready [3];
  logic [3:0]  a_start [3];
  logic [31:0] a_size  [3];
  logic [31:0] a_run   [3];

  assign a_idle[0] = if0.ap_idle;   assign a_idle[1] = if1.ap_idle;   assign a_idle[2] = if2.ap_idle;
  assign a_done[0] = if0.ap_done;   assign a_done[1] = if1.ap_done;   assign a_done[2] = if2.ap_done;
  assign a_ready[0] = if0.ap_ready; assign a_ready[1] = if1.ap_ready;
  assign a_ready[2] = if2.ap_ready;
  assign a_start[0] = if0.ch_start; assign a_start[1] = if1.ch_start;
  assign a_start[2] = if2.ch_start;
  assign a_size[0] = if0.ch_xfer_size_in_bytes;
  assign a_size[1] = if1.ch_xfer_size_in_bytes;
  assign a_size[2] = if2.ch_xfer_size_in_bytes;
  assign a_run[0] = if0.run_cycles; assign a_run[1] = if1.run_cycles;
  assign a_run[2] = {28'h0, if2.run_cycles};

  task automatic chk(input string name, input int id, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[dut%0d]: got 0x%0h expected 0x%0h", name, id, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference model: per instance, a run is "busy" from launch until every enabled channel has
  // reported; chain instances then "hold" done until continue is seen.
  bit              chain_m [3] = '{1'b0, 1'b1, 1'b0};
  longint unsigned cmax    [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};
  bit              busy [3], hold [3], pend [3], first [3];
  logic [3:0]      left [3];
  longint unsigned cnt  [3];
  bit              m_prev;
  logic            e_idle [3], e_done [3], e_ready [3];
  logic [3:0]      e_start [3];
  logic [31:0]     e_size [3];

  always @(posedge clk) begin
    bit st_edge;
    bit pulse;
    st_edge = ap_start && !m_prev;
    m_prev  = rst ? 1'b0 : ap_start;
    for (int k = 0; k < 3; k++) begin
      e_ready[k] = 1'b0;
      e_start[k] = 4'h0;
      if (rst) begin
        busy[k] = 0; hold[k] = 0; pend[k] = 0; first[k] = 0; cnt[k] = 0;
        e_size[k] = Def; e_done[k] = 1'b0; e_idle[k] = 1'b1;
      end else begin
        pulse = 0;
        if (!busy[k] && !hold[k]) begin
          if (st_edge || pend[k]) begin
            pend[k] = 0; busy[k] = 1; first[k] = 1; cnt[k] = 0;
            left[k] = (mask == 4'h0) ? 4'hf : mask;
            e_start[k] = left[k];
            e_size[k] = (size == 32'h0) ? Def : size;
          end
        end else begin
          if (st_edge) pend[k] = 1;
          if (busy[k]) begin
            if (cnt[k] < cmax[k]) cnt[k]++;
            if (first[k]) first[k] = 0;
            else begin
              left[k] = left[k] & ~ch_done;
              if (left[k] == 4'h0) begin
                busy[k] = 0; pulse = 1; hold[k] = chain_m[k];
              end
            end
          end else if (ap_continue) begin
            hold[k] = 0;
          end
        end
        e_ready[k] = pulse;
        e_done[k]  = pulse || hold[k];
        e_idle[k]  = !busy[k] && !hold[k];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        chk("model_idle", k, {31'h0, a_idle[k]}, {31'h0, e_idle[k]});
        chk("model_done", k, {31'h0, a_done[k]}, {31'h0, e_done[k]});
        chk("model_ready", k, {31'h0, a_ready[k]}, {31'h0, e_ready[k]});
        chk("model_ch_start", k, {28'h0, a_start[k]}, {28'h0, e_start[k]});
        chk("model_size", k, a_size[k], e_size[k]);
        chk("model_run_cycles", k, a_run[k], cnt[k][31:0]);
      end
    end
  end

  initial begin
    int nrdy;
    // Reset values.
    tick(); tick();
    chk_en = 1'b1;
    tick();
    chk("rst_idle", 0, {31'h0, a_idle[0]}, 1);
    chk("rst_done", 0, {31'h0, a_done[0]}, 0);
    chk("rst_ready", 0, {31'h0, a_ready[0]}, 0);
    chk("rst_ch_start", 0, {28'h0, a_start[0]}, 0);
    chk("rst_run_cycles", 0, a_run[0], 0);
    chk("rst_size", 0, a_size[0], Def);
    rst = 1'b0;
    tick();

    // hs, mask=0, size=0: dones on channels 0..3 at t+5..t+8.
    ap_start = 1'b1;                          // cycle t
    tick();                                   // t+1
    chk("launch_ch_start", 0, {28'h0, a_start[0]}, 4'hf);
    chk("launch_size", 0, a_size[0], Def);
    chk("launch_idle", 0, {31'h0, a_idle[0]}, 0);
    tick();                                   // t+2
    chk("launch_one_cycle", 0, {28'h0, a_start[0]}, 0);
    tick(); tick(); tick();                   // t+5
    for (int i = 0; i < 4; i++) begin
      ch_done = 4'(1 << i);
      tick();
    end                                       // t+9
    ch_done = 4'h0;
    chk("hs_done", 0, {31'h0, a_done[0]}, 1);
    chk("hs_ready", 0, {31'h0, a_ready[0]}, 1);
    chk("hs_idle", 0, {31'h0, a_idle[0]}, 1);
    chk("hs_run_cycles", 0, a_run[0], 8);
    chk("chain_done", 1, {31'h0, a_done[1]}, 1);
    nrdy = 0;
    for (int i = 0; i < 10; i++) begin
      nrdy += int'(a_ready[1]);
      if (i == 1) chk("hs_done_pulse", 0, {31'h0, a_done[0]}, 0);
      tick();
    end
    nrdy += int'(a_ready[1]);
    chk("chain_done_held", 1, {31'h0, a_done[1]}, 1);
    chk("chain_ready_once", 1, nrdy, 1);
    ap_continue = 1'b1;                       // cycle c
    tick();
    ap_continue = 1'b0;
    chk("chain_cont_done", 1, {31'h0, a_done[1]}, 0);
    chk("chain_cont_idle", 1, {31'h0, a_idle[1]}, 1);

    // mask=0101: masked dones ignored, simultaneous enabled dones complete.
    ap_start = 1'b0;
    tick();
    mask = 4'b0101; size = 32'd100; ap_start = 1'b1;
    tick();
    chk("mask_ch_start", 0, {28'h0, a_start[0]}, 4'b0101);
    chk("mask_size", 0, a_size[0], 100);
    tick();
    ch_done = 4'b1010;
    tick(); tick();
    ch_done = 4'h0;
    tick();
    chk("masked_no_done", 0, {31'h0, a_done[0]}, 0);
    chk("masked_busy", 0, {31'h0, a_idle[0]}, 0);
    ch_done = 4'b0101;                        // cycle d
    tick();
    ch_done = 4'h0;
    chk("simul_done", 0, {31'h0, a_done[0]}, 1);
    ap_continue = 1'b1;
    tick();
    ap_continue = 1'b0;
    chk("chain_idle2", 1, {31'h0, a_idle[1]}, 1);

    // Pending start: one edge in RUN is queued, a second is dropped.
    ap_start = 1'b0;
    tick();
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    tick();
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    tick();
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    ch_done = 4'b0101;                        // cycle d
    tick();
    ch_done = 4'h0;
    chk("pend_done", 0, {31'h0, a_done[0]}, 1);
    chk("pend_no_start_yet", 0, {28'h0, a_start[0]}, 0);
    tick();                                   // d+2
    chk("pend_relaunch", 0, {28'h0, a_start[0]}, 4'b0101);
    chk("pend_relaunch_idle", 0, {31'h0, a_idle[0]}, 0);
    tick();
    ch_done = 4'b0101;
    tick();
    ch_done = 4'h0;
    chk("pend_run2_done", 0, {31'h0, a_done[0]}, 1);
    tick(); tick();
    chk("pend_dropped_start", 0, {28'h0, a_start[0]}, 0);
    chk("pend_dropped_idle", 0, {31'h0, a_idle[0]}, 1);
    ap_continue = 1'b1;
    tick();
    ap_continue = 1'b0;

    // Reset mid-run with ap_start held high.
    mask = 4'h0;
    ap_start = 1'b1;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_idle", 0, {31'h0, a_idle[0]}, 1);
    chk("mid_rst_ch_start", 0, {28'h0, a_start[0]}, 0);
    chk("mid_rst_run_cycles", 0, a_run[0], 0);
    chk("mid_rst_size", 0, a_size[0], Def);
    ch_done = 4'hf;
    tick();
    rst = 1'b0; ch_done = 4'h0; size = 32'h0;   // cycle r
    tick();
    chk("rel_launch", 0, {28'h0, a_start[0]}, 4'hf);
    chk("rel_no_done", 0, {31'h0, a_done[0]}, 0);
    ch_done = 4'hf;                           // arrives in LAUNCH, ignored
    tick();
    ch_done = 4'h0;
    chk("launch_done_ignored", 0, {31'h0, a_done[0]}, 0);
    tick();
    ch_done = 4'hf;
    tick();
    ch_done = 4'h0;
    chk("rel_done", 0, {31'h0, a_done[0]}, 1);
    tick();
    chk("rel_single_launch", 0, {28'h0, a_start[0]}, 0);
    chk("rel_idle", 0, {31'h0, a_idle[0]}, 1);

    // 20-cycle run: narrow counter saturates.
    ap_start = 1'b0; ap_continue = 1'b1;
    tick();
    ap_continue = 1'b0;
    tick();
    ap_start = 1'b1;                          // cycle t
    tick();
    for (int i = 0; i < 19; i++) tick();      // t+20
    ch_done = 4'hf;
    tick();
    ch_done = 4'h0;
    ap_start = 1'b0;
    chk("sat_run_cycles", 2, a_run[2], 15);
    chk("wide_run_cycles", 0, a_run[0], 20);
    chk("chain_run_cycles", 1, a_run[1], 20);
    ap_continue = 1'b1;
    tick();
    ap_continue = 1'b0;

    // Randomized traffic checked by the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) ap_start = ~ap_start;
      ch_done = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      ap_continue = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 30) == 0) mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 30) == 0) size = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    tick();
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
